// File: rtl/bin_scan_scheduler.sv
// bin_scan_scheduler: round-robin bin display scan with edge-triggered full-bin alert preemption.
// Optional `ALERT_TIMEOUT_EN auto-acknowledges an alert after ALERT_DWELLS dwell ticks.
module bin_scan_scheduler #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int FULL_THRESH  = 230,
    parameter int ALERT_DWELLS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_bin1_cap,
    input  logic [7:0] i_bin2_cap,
    input  logic [7:0] i_bin3_cap,
    input  logic       i_hold,
    input  logic       i_ack,
    output logic       o_sel1,
    output logic       o_sel2,
    output logic       o_sel3,
    output logic [1:0] o_cur_bin,
    output logic       o_alert_active,
    output logic [2:0] o_pending,
    output logic       o_dwell_tick
);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0] TC = CW'(DWELL_CYCLES - 1);

    if (DWELL_CYCLES < 2 || ALERT_DWELLS < 1) begin : g_bad_param
        $error("bin_scan_scheduler: DWELL_CYCLES must be >= 2 and ALERT_DWELLS >= 1");
    end

    typedef enum logic {SCAN, ALERT} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [1:0]    r_cur, w_cur;
    logic [2:0]    r_sel, r_pending, r_full_q;
    logic [2:0]    w_full, w_clr, w_pending;
    logic          w_tick, w_timeout, w_ack;

    function automatic logic [1:0] lowest(input logic [2:0] p);
        return p[0] ? 2'd0 : p[1] ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:0] next_bin(input logic [1:0] b);
        return (b == 2'd2) ? 2'd0 : b + 2'd1;
    endfunction

    assign w_full    = {i_bin3_cap >= 8'(FULL_THRESH), i_bin2_cap >= 8'(FULL_THRESH), i_bin1_cap >= 8'(FULL_THRESH)};
    assign w_tick    = (r_cnt == TC) && (r_state == ALERT || !i_hold);
    assign w_ack     = (r_state == ALERT) && (i_ack || w_timeout);
    assign w_clr     = w_ack ? (3'b001 << r_cur) : 3'b000;
    // a new rising edge outranks a clear of the same bit
    assign w_pending = (r_pending & ~w_clr) | (w_full & ~r_full_q);

`ifdef ALERT_TIMEOUT_EN
    localparam int TW = $clog2(ALERT_DWELLS + 1);
    logic [TW-1:0] r_to;

    assign w_timeout = w_tick && (r_to == TW'(ALERT_DWELLS - 1));

    // restarts on alert entry and whenever an (auto-)ack moves the display
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_to <= '0;
        else          r_to <= (r_state == SCAN || w_ack) ? '0 : r_to + TW'(w_tick);
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state = r_state;
        w_cur   = r_cur;
        w_cnt   = r_cnt;
        if (r_state == SCAN) begin
            if (|r_pending) begin
                w_state = ALERT;
                w_cur   = lowest(r_pending);
                w_cnt   = '0;
            end else if (!i_hold) begin
                w_cnt = w_tick ? '0 : r_cnt + 1'b1;
                w_cur = w_tick ? next_bin(r_cur) : r_cur;
            end
        end else begin
            w_cnt = w_tick ? '0 : r_cnt + 1'b1;
            if (w_ack && |w_pending) begin
                w_cur = lowest(w_pending);
            end else if (w_ack) begin
                w_state = SCAN;
                w_cur   = next_bin(r_cur);
                w_cnt   = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= SCAN;
            r_cnt     <= '0;
            r_cur     <= 2'd0;
            r_sel     <= 3'b001;
            r_pending <= 3'b000;
            r_full_q  <= 3'b000;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_cur     <= w_cur;
            r_sel     <= 3'b001 << w_cur;
            r_pending <= w_pending;
            r_full_q  <= w_full;
        end
    end

    assign o_sel1         = r_sel[0];
    assign o_sel2         = r_sel[1];
    assign o_sel3         = r_sel[2];
    assign o_cur_bin      = r_cur;
    assign o_alert_active = (r_state == ALERT);
    assign o_pending      = r_pending;
    assign o_dwell_tick   = w_tick;
endmodule

// File: doc/bin_scan_scheduler.md
# bin_scan_scheduler

Sequencer that drives the one-hot bin selects of the smart-waste display path. It rotates the displayed bin round-robin on a fixed dwell period and preempts the rotation when a bin newly crosses the full threshold. It holds an alerted bin on the display until it is acknowledged. Sits between the bin capacity sensors/operator buttons and the LED/seven-segment display datapath, replacing manual `sel1..sel3` switches.

## Interface
- `DWELL_CYCLES`, 50_000_000 — clock cycles each bin is shown in scan mode; legal range ≥ 2.
- `FULL_THRESH`, 230 — 8-bit capacity at or above which a bin counts as full.
- `ALERT_DWELLS`, 8 — dwell periods before an unacknowledged alert auto-clears; used only with `ALERT_TIMEOUT_EN`.
- `clk` in 1 — single clock domain.
- `rst` in 1 — asynchronous, active-low reset.
- `bin1_cap`, `bin2_cap`, `bin3_cap` in 8 each — bin fill levels, synchronous to `clk`.
- `hold` in 1 — level; freezes scan rotation.
- `ack` in 1 — single-cycle pulse acknowledging the alert on the current bin.
- `sel1`, `sel2`, `sel3` out 1 each — registered one-hot bin select.
- `cur_bin` out 2 — index of the selected bin: 0, 1 or 2.
- `alert_active` out 1 — high while in the ALERT state.
- `pending` out 3 — sticky per-bin alert flags; bit i corresponds to bin i+1.
- `dwell_tick` out 1 — one-cycle pulse when the dwell counter reaches its terminal count.

## Operation
- States are SCAN and ALERT. The dwell counter is `$clog2(DWELL_CYCLES)` bits wide and counts 0 to DWELL_CYCLES−1.
- Full detect: `full[i] = cap_i >= FULL_THRESH`, with `full_q[i]` as its registered copy. A rising edge (`full[i] & ~full_q[i]`) sets `pending[i]`.
- `pending[i]` is edge-triggered. A bin that stays full does not re-raise after an ack; it must drop below threshold and then cross again.
- SCAN behaviour:
  - The counter increments each cycle unless `hold`=1.
  - At terminal count, `dwell_tick` pulses, the counter returns to 0, and `cur_bin` advances 0→1→2→0.
  - `hold` freezes both the counter and `cur_bin`; `dwell_tick` stays low while held.
- SCAN → ALERT: if any `pending` bit is set, the block selects the lowest-index pending bin and clears the counter. This takes priority over hold and over a dwell advance in the same cycle.
- ALERT behaviour:
  - `cur_bin` is frozen; `hold` is ignored.
  - The counter keeps running and `dwell_tick` keeps pulsing.
  - `ack` clears `pending[cur_bin]`. The block then moves to the lowest remaining pending bin and stays in ALERT. If none remain, it returns to SCAN at `(cur_bin+1) mod 3` with the counter cleared.
  - `ack` in SCAN is ignored.
- Simultaneous set and clear of the same `pending` bit: set wins, and the bin remains in alert.
- `sel1..sel3` always equal the one-hot decode of `cur_bin`. Exactly one select is high at all times, including during reset.

## Timing
- Reset values: SCAN state, `cur_bin`=0, `sel1`=1, `sel2`=0, `sel3`=0, `alert_active`=0, `pending`=0, `dwell_tick`=0, counter=0, `full_q`=0.
- Because `full_q` resets to 0, any bin already full when reset is released raises an alert.
- Alert latency, where edge k is the first rising clock edge at which `cap_i >= FULL_THRESH` is sampled:
  - `pending[i]` is set at edge k.
  - State, `cur_bin`, `sel*` and `alert_active` update at edge k+1.
- `ack` sampled at edge k: `pending`, state and selects update at edge k. The first SCAN dwell then lasts the full DWELL_CYCLES cycles.
- Scan period: in SCAN with `hold`=0, each bin is shown for exactly DWELL_CYCLES cycles.
- Reset asserted mid-alert: all state returns to reset values immediately and asynchronously.

## Configuration
- `ALERT_TIMEOUT_EN` defined:
  - In ALERT, a dwell-tick counter runs.
  - After ALERT_DWELLS ticks without `ack`, the block behaves exactly as if `ack` were pulsed.
  - The dwell-tick counter clears on each alert entry and on each bin change within ALERT.
- `ALERT_TIMEOUT_EN` undefined: ALERT persists until `ack` or reset. The `ALERT_DWELLS` parameter is unused and no timeout logic is present.

## Test plan
- Reset release with all caps at 0, DWELL_CYCLES=4 → `cur_bin` sequence is 0,1,2,0, each held 4 cycles; `dwell_tick` pulses every 4th cycle; selects are one-hot throughout.
- `hold`=1 for 10 cycles mid-dwell → `cur_bin` and the counter freeze, and no `dwell_tick` pulses. After release, the remaining dwell completes.
- `bin3_cap` steps 100→240 while `cur_bin`=0 → `pending`=3'b100 one edge later; `sel3`=1 and `alert_active`=1 two edges later. `ack` → return to SCAN with `cur_bin`=0.
- `bin1_cap` and `bin2_cap` both step to 250 in the same cycle → ALERT on bin 0. First `ack` moves to bin 1, still in ALERT. Second `ack` → SCAN with `cur_bin`=2. Holding the caps at 250 afterwards raises no new alert.
- `bin2` in ALERT; in the same cycle as `ack`, `bin2_cap` is re-crossed (drops below threshold beforehand) → `pending[1]` stays 1 and the block remains in ALERT on bin 1.
- With `ALERT_TIMEOUT_EN`, ALERT_DWELLS=2, DWELL_CYCLES=4, and no `ack` → ALERT auto-clears 8 cycles after entry. Without the macro → ALERT remains for 100 cycles.
